// File: rtl/vadf_decoder.sv
// rtl/vadf_decoder.sv - VADF compressed-word decoder with Hamming-protected location and error counters
module vadf_decoder #(
    parameter logic [1:0] A     = 2'd1,
    parameter logic [1:0] B     = 2'd2,
    parameter logic [1:0] C     = 2'd3,
    parameter int         CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode_sel,
    input  logic [15:0]      in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             err_corr,
    output logic             err_uncorr,
    output logic [CNT_W-1:0] corr_count,
    output logic [CNT_W-1:0] uncorr_count
);

    logic             s1_valid_q, s1_valid_d;
    logic [15:0]      s1_code_q, s1_code_d;
    logic [1:0]       s1_mode_q, s1_mode_d;
    logic [4:0]       s1_l_q, s1_l_d;
    logic             s1_corr_q, s1_corr_d;
    logic             s1_uncorr_q, s1_uncorr_d;

    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_data_q, out_data_d;
    logic             err_corr_q, err_corr_d;
    logic             err_uncorr_q, err_uncorr_d;
    logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
    logic [CNT_W-1:0] uncorr_cnt_q, uncorr_cnt_d;

    logic       s2_load;
    logic       out_fire;
    logic [4:0] l_raw, l_fix;
    logic [3:0] e_raw;
    logic [2:0] syn;
    logic       ham_en, par_err;
    logic [31:0] pow, recon;

    assign s2_load  = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_load;
    assign out_fire = out_valid_q && out_ready;

    // Field extraction, syndrome and single-bit location correction.
    always_comb begin
        l_raw   = 5'd0;
        e_raw   = 4'd0;
        ham_en  = 1'b0;
        par_err = 1'b0;
        if (mode_sel == A) begin
            l_raw   = in_code[14:10];
            e_raw   = in_code[9:6];
            ham_en  = 1'b1;
            par_err = in_code[15] ^ (^in_code[5:0]);
        end else if (mode_sel == B) begin
            l_raw  = in_code[11:7];
            e_raw  = in_code[6:3];
            ham_en = 1'b1;
        end else if (mode_sel == C) begin
            l_raw   = in_code[7:3];
            par_err = in_code[2] ^ (^in_code[7:3]);
        end
        syn = {e_raw[3] ^ l_raw[4] ^ l_raw[2] ^ l_raw[1],
               e_raw[2] ^ l_raw[4] ^ l_raw[3] ^ l_raw[1],
               e_raw[1] ^ l_raw[4] ^ l_raw[3] ^ l_raw[2]};
        l_fix = l_raw;
        if (ham_en) begin
            case (syn)
                3'b110:  l_fix[1] = ~l_raw[1];
                3'b101:  l_fix[2] = ~l_raw[2];
                3'b011:  l_fix[3] = ~l_raw[3];
                3'b111:  l_fix[4] = ~l_raw[4];
                default: l_fix = l_raw;
            endcase
        end
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_code_d   = s1_code_q;
        s1_mode_d   = s1_mode_q;
        s1_l_d      = s1_l_q;
        s1_corr_d   = s1_corr_q;
        s1_uncorr_d = s1_uncorr_q;
        if (in_ready) begin
            s1_valid_d  = in_valid;
            s1_code_d   = in_code;
            s1_mode_d   = mode_sel;
            s1_l_d      = l_fix;
            s1_corr_d   = ham_en && (syn != 3'b000);
            s1_uncorr_d = par_err || (ham_en && (e_raw[0] ^ l_raw[0]));
        end
    end

    // Reconstruction: leading one at L followed by as many mantissa bits as fit below it.
    always_comb begin
        pow   = 32'd1 << s1_l_q;
        recon = 32'd0;
        if (s1_mode_q == A) begin
            if (s1_code_q == 16'd0)
                recon = 32'd0;
            else if (s1_l_q < 5'd6)
                recon = pow | ({26'd0, s1_code_q[5:0]} & (pow - 32'd1));
            else
                recon = {25'd0, 1'b1, s1_code_q[5:0]} << (s1_l_q - 5'd6);
        end else if (s1_mode_q == B) begin
            if (s1_code_q[11:0] == 12'd0)
                recon = 32'd0;
            else if (s1_l_q < 5'd3)
                recon = pow | ({29'd0, s1_code_q[2:0]} & (pow - 32'd1));
            else
                recon = {28'd0, 1'b1, s1_code_q[2:0]} << (s1_l_q - 5'd3);
        end else if (s1_mode_q == C) begin
            if (s1_code_q[7:0] == 8'd0)
                recon = 32'd0;
            else if (s1_l_q == 5'd0)
                recon = 32'd1;
            else if (s1_l_q == 5'd1)
                recon = {30'd0, 1'b1, s1_code_q[0]};
            else
                recon = {29'd0, 1'b1, s1_code_q[1:0]} << (s1_l_q - 5'd2);
        end
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        err_corr_d   = err_corr_q;
        err_uncorr_d = err_uncorr_q;
        if (s2_load) begin
            out_valid_d  = s1_valid_q;
            out_data_d   = recon;
            err_corr_d   = s1_corr_q;
            err_uncorr_d = s1_uncorr_q;
        end
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        if (out_fire && err_corr_q && (corr_cnt_q != {CNT_W{1'b1}}))
            corr_cnt_d = corr_cnt_q + CNT_W'(1);
        if (out_fire && err_uncorr_q && (uncorr_cnt_q != {CNT_W{1'b1}}))
            uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_code_q    <= 16'd0;
            s1_mode_q    <= 2'd0;
            s1_l_q       <= 5'd0;
            s1_corr_q    <= 1'b0;
            s1_uncorr_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 32'd0;
            err_corr_q   <= 1'b0;
            err_uncorr_q <= 1'b0;
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_code_q    <= s1_code_d;
            s1_mode_q    <= s1_mode_d;
            s1_l_q       <= s1_l_d;
            s1_corr_q    <= s1_corr_d;
            s1_uncorr_q  <= s1_uncorr_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            err_corr_q   <= err_corr_d;
            err_uncorr_q <= err_uncorr_d;
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign err_corr     = err_corr_q;
    assign err_uncorr   = err_uncorr_q;
    assign corr_count   = corr_cnt_q;
    assign uncorr_count = uncorr_cnt_q;

endmodule

// File: tb/tb_vadf_decoder.sv
// tb/tb_vadf_decoder.sv - directed self-checking bench for vadf_decoder
module tb_vadf_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [1:0]  mode_sel;
    logic [15:0] in_code;

    logic        in_ready, out_valid, err_corr, err_uncorr;
    logic [31:0] out_data;
    logic [15:0] corr_count, uncorr_count;

    logic        sat_in_ready, sat_out_valid, sat_err_corr, sat_err_uncorr;
    logic [31:0] sat_out_data;
    logic [1:0]  sat_corr_count, sat_uncorr_count;

    int checks = 0;
    int failures = 0;
    int exp_corr = 0;
    int exp_uncorr = 0;

    always #5 clk = ~clk;

    vadf_decoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .mode_sel(mode_sel), .in_code(in_code), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .err_corr(err_corr),
        .err_uncorr(err_uncorr), .corr_count(corr_count), .uncorr_count(uncorr_count)
    );

    vadf_decoder #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sat_in_ready),
        .mode_sel(mode_sel), .in_code(in_code), .out_valid(sat_out_valid),
        .out_ready(out_ready), .out_data(sat_out_data), .err_corr(sat_err_corr),
        .err_uncorr(sat_err_uncorr), .corr_count(sat_corr_count),
        .uncorr_count(sat_uncorr_count)
    );

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic drive_check(input string name, input logic [1:0] m, input logic [15:0] code,
                               input logic [31:0] exp_d, input logic exp_c, input logic exp_u);
        @(negedge clk);
        in_valid = 1'b1; mode_sel = m; in_code = code; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL %s in_ready: got %b expected 1", name, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL %s early_valid: got %b expected 0", name, out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++; $display("FAIL %s latency: out_valid got %b expected 1", name, out_valid);
        end
        checks++;
        if (out_data !== exp_d) begin
            failures++; $display("FAIL %s out_data: got %h expected %h", name, out_data, exp_d);
        end
        checks++;
        if (err_corr !== exp_c || err_uncorr !== exp_u) begin
            failures++;
            $display("FAIL %s flags: got corr=%b uncorr=%b expected corr=%b uncorr=%b",
                     name, err_corr, err_uncorr, exp_c, exp_u);
        end
        checks++;
        if (sat_out_data !== exp_d || sat_err_corr !== exp_c || sat_err_uncorr !== exp_u) begin
            failures++;
            $display("FAIL %s sat_inst: got %h/%b/%b expected %h/%b/%b", name,
                     sat_out_data, sat_err_corr, sat_err_uncorr, exp_d, exp_c, exp_u);
        end
        if (exp_c) exp_corr++;
        if (exp_u) exp_uncorr++;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL %s duplicate: out_valid got %b expected 0", name, out_valid);
        end
        checks++;
        if (corr_count !== 16'(exp_corr) || uncorr_count !== 16'(exp_uncorr)) begin
            failures++;
            $display("FAIL %s counters: got %0d/%0d expected %0d/%0d", name,
                     corr_count, uncorr_count, exp_corr, exp_uncorr);
        end
        checks++;
        if (sat_corr_count !== 2'(sat3(exp_corr)) || sat_uncorr_count !== 2'(sat3(exp_uncorr))) begin
            failures++;
            $display("FAIL %s sat_counters: got %0d/%0d expected %0d/%0d", name,
                     sat_corr_count, sat_uncorr_count, sat3(exp_corr), sat3(exp_uncorr));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mode_sel = 2'd0; in_code = 16'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'd0 || err_corr !== 1'b0 || err_uncorr !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got v=%b d=%h c=%b u=%b expected 0",
                     out_valid, out_data, err_corr, err_uncorr);
        end
        checks++;
        if (corr_count !== 16'd0 || uncorr_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_counters: got %0d/%0d expected 0/0", corr_count, uncorr_count);
        end
        checks++;
        if (in_ready !== 1'b1 || sat_in_ready !== 1'b1 || sat_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready: got %b/%b/%b expected 1/1/0", in_ready, sat_in_ready, sat_out_valid);
        end
    endtask

    task automatic test_mode16();
        drive_check("m16_basic", 2'd1, 16'h3309, 32'h0000_1240, 1'b0, 1'b0);
        drive_check("m16_l5", 2'd1, 16'h16FF, 32'h0000_003F, 1'b0, 1'b0);
        drive_check("m16_parity", 2'd1, 16'hB309, 32'h0000_1240, 1'b0, 1'b1);
        drive_check("m16_e0", 2'd1, 16'h3349, 32'h0000_1240, 1'b0, 1'b1);
    endtask

    task automatic test_correction();
        drive_check("m16_corr_l3", 2'd1, 16'h1309, 32'h0000_1240, 1'b1, 1'b0);
        drive_check("m16_corr_par", 2'd1, 16'h9309, 32'h0000_1240, 1'b1, 1'b1);
        drive_check("m12_corr_l4", 2'd2, 16'h0BBF, 32'h0000_00F0, 1'b1, 1'b0);
    endtask

    task automatic test_mode12();
        drive_check("m12_basic", 2'd2, 16'h03BF, 32'h0000_00F0, 1'b0, 1'b0);
        drive_check("m12_l2", 2'd2, 16'hF165, 32'h0000_0005, 1'b0, 1'b0);
    endtask

    task automatic test_mode8();
        drive_check("m8_top", 2'd3, 16'h00FC, 32'h8000_0000, 1'b0, 1'b0);
        drive_check("m8_parity", 2'd3, 16'h007C, 32'h0000_8000, 1'b0, 1'b1);
        drive_check("m8_l1", 2'd3, 16'hAB0D, 32'h0000_0003, 1'b0, 1'b0);
    endtask

    task automatic test_zero_and_bad_mode();
        drive_check("zero16", 2'd1, 16'h0000, 32'h0, 1'b0, 1'b0);
        drive_check("zero12", 2'd2, 16'hF000, 32'h0, 1'b0, 1'b0);
        drive_check("zero8", 2'd3, 16'hFF00, 32'h0, 1'b0, 1'b0);
        drive_check("bad_mode", 2'd0, 16'h3309, 32'h0, 1'b0, 1'b0);
        drive_check("bad_mode_err", 2'd0, 16'h007C, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [1:0]  bm[8];
        logic [15:0] bc[8];
        logic [31:0] bd[8];
        logic [7:0]  bcf, buf_;
        logic [3:0]  rdy_pat;
        int ni = 0, no = 0, cyc = 0;
        bit saw_block = 0, pv = 0, pr = 0;
        logic [31:0] pd = 32'd0;
        logic pc = 1'b0, pu = 1'b0;
        bm = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd1};
        bc = '{16'h3309, 16'h16FF, 16'h03BF, 16'h0165, 16'h00FC, 16'h000D, 16'h007C, 16'h1309};
        bd = '{32'h1240, 32'h3F, 32'hF0, 32'h5, 32'h8000_0000, 32'h3, 32'h8000, 32'h1240};
        bcf = 8'b1000_0000;
        buf_ = 8'b0100_0000;
        rdy_pat = 4'b1001;
        while (no < 8 && cyc < 100) begin
            @(negedge clk);
            if (pv && !pr) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== pd || err_corr !== pc || err_uncorr !== pu) begin
                    failures++;
                    $display("FAIL b2b_stall_stable: got %b/%h expected 1/%h", out_valid, out_data, pd);
                end
            end
            out_ready = rdy_pat[cyc % 4];
            if (ni < 8) begin
                in_valid = 1'b1; mode_sel = bm[ni]; in_code = bc[ni];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (in_valid && !in_ready) saw_block = 1;
            if (out_valid && out_ready) begin
                checks++;
                if (out_data !== bd[no] || err_corr !== bcf[no] || err_uncorr !== buf_[no]) begin
                    failures++;
                    $display("FAIL b2b_beat%0d: got %h/%b/%b expected %h/%b/%b", no,
                             out_data, err_corr, err_uncorr, bd[no], bcf[no], buf_[no]);
                end
                if (bcf[no]) exp_corr++;
                if (buf_[no]) exp_uncorr++;
                no++;
            end
            if (in_valid && in_ready) ni++;
            pv = out_valid; pr = out_ready; pd = out_data; pc = err_corr; pu = err_uncorr;
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (no != 8) begin
            failures++; $display("FAIL b2b_count: got %0d results expected 8", no);
        end
        checks++;
        if (!saw_block) begin
            failures++; $display("FAIL b2b_backpressure: in_ready never dropped, expected a drop");
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL b2b_extra: out_valid got %b expected 0", out_valid);
        end
        checks++;
        if (corr_count !== 16'(exp_corr) || uncorr_count !== 16'(exp_uncorr)) begin
            failures++;
            $display("FAIL b2b_counters: got %0d/%0d expected %0d/%0d",
                     corr_count, uncorr_count, exp_corr, exp_uncorr);
        end
    endtask

    task automatic test_reset_inflight();
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; mode_sel = 2'd1; in_code = 16'h1309;
        @(negedge clk);
        mode_sel = 2'd2; in_code = 16'h03BF;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_inflight_full: got v=%b rdy=%b expected 1/0", out_valid, in_ready);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || corr_count !== 16'd0 || uncorr_count !== 16'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_inflight_clear: got v=%b c=%0d u=%0d rdy=%b expected 0/0/0/1",
                     out_valid, corr_count, uncorr_count, in_ready);
        end
        exp_corr = 0;
        exp_uncorr = 0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL rst_inflight_flush: out_valid got %b expected 0", out_valid);
        end
        drive_check("after_rst", 2'd1, 16'h3309, 32'h0000_1240, 1'b0, 1'b0);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++)
            drive_check("sat_beat", 2'd1, 16'h1309, 32'h0000_1240, 1'b1, 1'b0);
        checks++;
        if (sat_corr_count !== 2'd3) begin
            failures++; $display("FAIL sat_corr: got %0d expected 3", sat_corr_count);
        end
        checks++;
        if (corr_count !== 16'd5) begin
            failures++; $display("FAIL wide_corr: got %0d expected 5", corr_count);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mode_sel = 2'd0; in_code = 16'd0;
        test_reset();
        test_mode16();
        test_correction();
        test_mode12();
        test_mode8();
        test_zero_and_bad_mode();
        test_back_to_back();
        test_reset_inflight();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
